alu_mode_sequencer: RTL and testbench

Parametrised, clocked successor to the board-level ALU front end. Two push-buttons step the ALU mode forward and backward; each button goes through its own synchroniser, debounce and edge detector. The block evaluates arithmetic, logical and comparison operations on OP_W-bit operands, and multiplies and divides iteratively over OP_W cycles. Registered results, flags and a busy/valid handshake feed the display and LED muxing at top level.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_mode_sequencer_key_event.sv | 46 ++++
 rtl/alu_mode_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_alu_mode_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU mode sequencer: modes, sub-operation codes
// and the evaluation FSM state type.
package alu_seq_pkg;

  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_CMP   = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] ARITH_ADD = 2'd0;
  localparam logic [1:0] ARITH_SUB = 2'd1;
  localparam logic [1:0] ARITH_MUL = 2'd2;
  localparam logic [1:0] ARITH_DIV = 2'd3;

  localparam logic [1:0] LOGIC_AND = 2'd0;
  localparam logic [1:0] LOGIC_OR  = 2'd1;
  localparam logic [1:0] LOGIC_XOR = 2'd2;
  localparam logic [1:0] LOGIC_NOT = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mode_sequencer_key_event.sv
// Push-button front end: 2-flop synchroniser, debounce counter and a
// one-cycle pulse when the debounced (active-low) level falls.
module key_event #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_mode_sequencer.sv
// Button-stepped ALU front end: re-evaluates whenever mode/sub-op/operands
// change, with iterative shift-add multiply and restoring divide.
module alu_mode_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int DB_CYCLES = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              KEY_NEXT,
  input  logic              KEY_PREV,
  input  logic [OP_W-1:0]   OP_A,
  input  logic [OP_W-1:0]   OP_B,
  input  logic [1:0]        SUB_SEL,
  output logic [1:0]        MODE,
  output logic [2*OP_W-1:0] RESULT,
  output logic              FLAG,
  output logic              BUSY,
  output logic              VALID,
  output logic              STATE_DBG
);

  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(OP_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OP_W - 1);

  logic ev_next, ev_prev;

  key_event #(.DB_CYCLES(DB_CYCLES)) u_key_next (
    .clk_i(CLK), .rst_i(RST), .key_n_i(KEY_NEXT), .press_o(ev_next)
  );
  key_event #(.DB_CYCLES(DB_CYCLES)) u_key_prev (
    .clk_i(CLK), .rst_i(RST), .key_n_i(KEY_PREV), .press_o(ev_prev)
  );

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d, snap_mode_q, snap_mode_d, snap_sub_q, snap_sub_d;
  logic [OP_W-1:0]   snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic              snap_vld_q, snap_vld_d;
  logic [RW-1:0]     result_q, result_d;
  logic              flag_q, flag_d, busy_q, busy_d, valid_q, valid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     prod_q, prod_d, mcand_q, mcand_d;
  logic [OP_W-1:0]   mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d;

  logic [OP_W:0]     sum_w, diff_w, rem_sh;
  logic [RW-1:0]     res_1c, prod_step;
  logic              flag_1c, div_ok, is_iter, is_mul;
  logic [OP_W-1:0]   rem_step, quo_step;

  assign is_mul  = (snap_mode_q == MODE_ARITH) && (snap_sub_q == ARITH_MUL);
  assign is_iter = is_mul || ((snap_mode_q == MODE_ARITH) && (snap_sub_q == ARITH_DIV));

  // Single-cycle operations, evaluated on the latched snapshot.
  always_comb begin
    sum_w   = {1'b0, snap_a_q} + {1'b0, snap_b_q};
    diff_w  = {1'b0, snap_a_q} - {1'b0, snap_b_q};
    res_1c  = '0;
    flag_1c = 1'b0;
    case (snap_mode_q)
      MODE_ARITH: begin
        if (snap_sub_q == ARITH_ADD) begin
          res_1c[OP_W-1:0] = sum_w[OP_W-1:0];
          flag_1c          = sum_w[OP_W];
        end else begin
          res_1c[OP_W-1:0] = diff_w[OP_W-1:0];
          flag_1c          = diff_w[OP_W];
        end
      end
      MODE_LOGIC: begin
        case (snap_sub_q)
          LOGIC_AND: res_1c[OP_W-1:0] = snap_a_q & snap_b_q;
          LOGIC_OR:  res_1c[OP_W-1:0] = snap_a_q | snap_b_q;
          LOGIC_XOR: res_1c[OP_W-1:0] = snap_a_q ^ snap_b_q;
          default:   res_1c[OP_W-1:0] = ~snap_a_q;
        endcase
      end
      MODE_CMP: res_1c[2:0] = {snap_a_q > snap_b_q, snap_a_q < snap_b_q, snap_a_q == snap_b_q};
      default: res_1c = '0;
    endcase
  end

  // One multiply and one divide step per EXEC cycle; a zero divisor
  // naturally yields all-ones quotient and remainder equal to A.
  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh    = {rem_q, quo_q[OP_W-1]};
    div_ok    = (rem_sh >= {1'b0, snap_b_q});
    rem_step  = div_ok ? (rem_sh[OP_W-1:0] - snap_b_q) : rem_sh[OP_W-1:0];
    quo_step  = {quo_q[OP_W-2:0], div_ok};
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    snap_mode_d = snap_mode_q;
    snap_sub_d  = snap_sub_q;
    snap_a_d    = snap_a_q;
    snap_b_d    = snap_b_q;
    snap_vld_d  = snap_vld_q;
    result_d    = result_q;
    flag_d      = flag_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    case (state_q)
      IDLE: begin
        if (ev_next && !ev_prev)      mode_d = mode_q + 2'd1;
        else if (ev_prev && !ev_next) mode_d = mode_q - 2'd1;
        if (!snap_vld_q ||
            ({mode_q, SUB_SEL, OP_A, OP_B} != {snap_mode_q, snap_sub_q, snap_a_q, snap_b_q})) begin
          snap_mode_d = mode_q;
          snap_sub_d  = SUB_SEL;
          snap_a_d    = OP_A;
          snap_b_d    = OP_B;
          snap_vld_d  = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          prod_d      = '0;
          mcand_d     = {{OP_W{1'b0}}, OP_A};
          mplier_d    = OP_B;
          rem_d       = '0;
          quo_d       = OP_A;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (!is_iter) begin
          result_d = res_1c;
          flag_d   = flag_1c;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          rem_d    = rem_step;
          quo_d    = quo_step;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = is_mul ? prod_step : {rem_step, quo_step};
            flag_d   = is_mul ? (|prod_step[RW-1:OP_W]) : (snap_b_q == '0);
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      mode_q      <= MODE_ARITH;
      snap_mode_q <= '0;
      snap_sub_q  <= '0;
      snap_a_q    <= '0;
      snap_b_q    <= '0;
      snap_vld_q  <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      snap_mode_q <= snap_mode_d;
      snap_sub_q  <= snap_sub_d;
      snap_a_q    <= snap_a_d;
      snap_b_q    <= snap_b_d;
      snap_vld_q  <= snap_vld_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
    end
  end

  assign MODE      = mode_q;
  assign RESULT    = result_q;
  assign FLAG      = flag_q;
  assign BUSY      = busy_q;
  assign VALID     = valid_q;
  assign STATE_DBG = (state_q == EXEC);

endmodule

// File: tb/tb_alu_mode_sequencer.sv
// Bench for alu_mode_sequencer (OP_W=4, DB_CYCLES=4): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_mode_sequencer;

  localparam int OP_W = 4;
  localparam int DB   = 4;

  logic       clk = 1'b0;
  logic       rst, key_next, key_prev;
  logic [3:0] op_a, op_b;
  logic [1:0] sub_sel, mode;
  logic [7:0] result;
  logic       flag, busy, valid, state_dbg;

  int checks = 0;
  int errors = 0;
  int cur_mode, cur_sub, cur_a, cur_b;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  alu_mode_sequencer #(.OP_W(OP_W), .DB_CYCLES(DB)) dut (
    .CLK(clk), .RST(rst), .KEY_NEXT(key_next), .KEY_PREV(key_prev),
    .OP_A(op_a), .OP_B(op_b), .SUB_SEL(sub_sel), .MODE(mode),
    .RESULT(result), .FLAG(flag), .BUSY(busy), .VALID(valid), .STATE_DBG(state_dbg)
  );

  // Reference model: plain integer arithmetic per mode/sub-op.
  function automatic void model(input int m, input int s, input int a, input int b,
                                output logic [7:0] r, output logic f, output int lat);
    r = 8'h00; f = 1'b0; lat = 2;
    case (m)
      0: case (s)
           0: begin r = 8'((a + b) % 16); f = (a + b) > 15; end
           1: begin r = 8'((a - b + 16) % 16); f = a < b; end
           2: begin r = 8'(a * b); f = (a * b) > 15; lat = OP_W + 1; end
           default: begin
             lat = OP_W + 1;
             if (b == 0) begin r = 8'(a * 16 + 15); f = 1'b1; end
             else r = 8'((a % b) * 16 + a / b);
           end
         endcase
      1: case (s)
           0: r = 8'(a & b);
           1: r = 8'(a | b);
           2: r = 8'(a ^ b);
           default: r = 8'((~a) & 15);
         endcase
      2: r = {5'b0, a > b, a < b, a == b};
      default: r = 8'h00;
    endcase
  endfunction

  task automatic drive(input int s, input int a, input int b);
    sub_sel = 2'(s); op_a = 4'(a); op_b = 4'(b);
    cur_sub = s; cur_a = a; cur_b = b;
  endtask

  // Counts edges until VALID is seen (bounded); to=1 if it never came.
  task automatic run_eval(output int n, output logic [7:0] r, output logic f, output bit to);
    to = 1'b1; n = 0; r = 8'h00; f = 1'b0;
    for (int i = 0; i < 40 && to; i++) begin
      @(posedge clk); #1;
      n++;
      if (valid) begin r = result; f = flag; to = 1'b0; end
    end
  endtask

  task automatic press(input logic nx, input logic pv, input int low,
                       output int nvalid, output int nchg, output logic [7:0] r, output logic f);
    logic [1:0] last;
    last = mode; nvalid = 0; nchg = 0; r = 8'h00; f = 1'b0;
    key_next = ~nx; key_prev = ~pv;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i + 1 == low) begin key_next = 1'b1; key_prev = 1'b1; end
      if (valid) begin nvalid++; r = result; f = flag; end
      if (mode != last) begin nchg++; last = mode; end
    end
  endtask

  task automatic test_reset();
    int n; logic [7:0] r; logic f; bit to;
    rst = 1'b1; key_next = 1'b1; key_prev = 1'b1; drive(0, 0, 0); cur_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mode, result, busy, valid, state_dbg, flag} !== 14'h0) begin
      errors++;
      $display("FAIL reset_state got mode=%0d res=%h busy=%b valid=%b st=%b flag=%b exp all 0",
               mode, result, busy, valid, state_dbg, flag);
    end
    rst = 1'b0;
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 2 || r !== 8'h00 || f !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_eval got to=%0d lat=%0d res=%h flag=%b exp lat=2 res=00 flag=0", to, n, r, f);
    end
  endtask

  task automatic test_arith();
    int s_t[4]   = '{0, 1, 0, 1};
    int a_t[4]   = '{9, 3, 2, 7};
    int b_t[4]   = '{8, 5, 3, 7};
    int r_t[4]   = '{8'h01, 8'h0E, 8'h05, 8'h00};
    int f_t[4]   = '{1, 1, 0, 0};
    int n; logic [7:0] r; logic f; bit to;
    for (int i = 0; i < 4; i++) begin
      drive(s_t[i], a_t[i], b_t[i]);
      run_eval(n, r, f, to);
      checks++;
      if (to || n != 2 || r !== 8'(r_t[i]) || f !== 1'(f_t[i])) begin
        errors++;
        $display("FAIL arith_%0d got to=%0d lat=%0d res=%h flag=%b exp lat=2 res=%h flag=%0d",
                 i, to, n, r, f, r_t[i], f_t[i]);
      end
    end
  endtask

  task automatic test_mul();
    int n; logic [7:0] r; logic f; bit to;
    drive(2, 15, 15);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (i < 5) begin
        if (busy !== 1'b1 || valid !== 1'b0 || state_dbg !== 1'b1) begin
          errors++;
          $display("FAIL mul_busy_%0d got busy=%b valid=%b st=%b exp 1 0 1", i, busy, valid, state_dbg);
        end
      end else if ({busy, valid, result, flag} !== {1'b0, 1'b1, 8'hE1, 1'b1}) begin
        errors++;
        $display("FAIL mul_done got busy=%b valid=%b res=%h flag=%b exp 0 1 e1 1", busy, valid, result, flag);
      end
      if (i == 2) drive(2, 15, 3);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || result !== 8'hE1) begin
      errors++;
      $display("FAIL mul_hold got busy=%b res=%h exp busy=1 res=e1", busy, result);
    end
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 4 || r !== 8'h2D || f !== 1'b1) begin
      errors++;
      $display("FAIL mul_deferred got to=%0d lat=%0d res=%h flag=%b exp lat=4 res=2d flag=1", to, n, r, f);
    end
    drive(2, 3, 5);
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 5 || r !== 8'h0F || f !== 1'b0) begin
      errors++;
      $display("FAIL mul_small got to=%0d lat=%0d res=%h flag=%b exp lat=5 res=0f flag=0", to, n, r, f);
    end
  endtask

  task automatic test_div();
    int n; logic [7:0] r; logic f; bit to;
    drive(3, 13, 4);
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 5 || r !== 8'h13 || f !== 1'b0) begin
      errors++;
      $display("FAIL div got to=%0d lat=%0d res=%h flag=%b exp lat=5 res=13 flag=0", to, n, r, f);
    end
    drive(3, 13, 0);
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 5 || r !== 8'hDF || f !== 1'b1) begin
      errors++;
      $display("FAIL div_zero got to=%0d lat=%0d res=%h flag=%b exp lat=5 res=df flag=1", to, n, r, f);
    end
  endtask

  task automatic test_keys();
    int nv, nc; logic [7:0] r; logic f;
    press(1'b0, 1'b1, 8, nv, nc, r, f);
    cur_mode = 3;
    checks++;
    if (mode !== 2'd3 || nc != 1 || nv != 1 || r !== 8'h00 || f !== 1'b0) begin
      errors++;
      $display("FAIL key_prev got mode=%0d chg=%0d valids=%0d res=%h exp mode=3 chg=1 valids=1 res=00", mode, nc, nv, r);
    end
    press(1'b1, 1'b0, 2, nv, nc, r, f);
    checks++;
    if (mode !== 2'd3 || nc != 0 || nv != 0) begin
      errors++;
      $display("FAIL key_glitch got mode=%0d chg=%0d valids=%0d exp mode=3 chg=0 valids=0", mode, nc, nv);
    end
    press(1'b1, 1'b1, 8, nv, nc, r, f);
    checks++;
    if (mode !== 2'd3 || nc != 0 || nv != 0) begin
      errors++;
      $display("FAIL key_both got mode=%0d chg=%0d valids=%0d exp mode=3 chg=0 valids=0", mode, nc, nv);
    end
    press(1'b1, 1'b0, 8, nv, nc, r, f);
    cur_mode = 0;
    checks++;
    if (mode !== 2'd0 || nc != 1 || nv != 1 || r !== 8'hDF || f !== 1'b1) begin
      errors++;
      $display("FAIL key_wrap got mode=%0d chg=%0d valids=%0d res=%h flag=%b exp mode=0 chg=1 valids=1 res=df flag=1",
               mode, nc, nv, r, f);
    end
  endtask

  task automatic test_key_while_busy();
    int nv, nc; logic [7:0] r; logic f;
    logic [1:0] last;
    nv = 0; nc = 0; r = 8'h00; f = 1'b0; last = mode;
    key_next = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    drive(2, 7, 6);
    // The debounced press lands inside the multiply, so it must be dropped.
    for (int i = 3; i < 30; i++) begin
      @(posedge clk); #1;
      if (i + 1 == 8) key_next = 1'b1;
      if (valid) begin nv++; r = result; f = flag; end
      if (mode != last) begin nc++; last = mode; end
    end
    checks++;
    if (mode !== 2'd0 || nc != 0 || nv != 1 || r !== 8'h2A || f !== 1'b1) begin
      errors++;
      $display("FAIL key_busy got mode=%0d chg=%0d valids=%0d res=%h flag=%b exp mode=0 chg=0 valids=1 res=2a flag=1",
               mode, nc, nv, r, f);
    end
  endtask

  task automatic test_reset_mid_exec();
    int n; logic [7:0] r; logic f; bit to;
    drive(2, 9, 6);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy got busy=%b exp 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    cur_mode = 0;
    checks++;
    if ({mode, result, busy, valid, state_dbg, flag} !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid got mode=%0d res=%h busy=%b valid=%b st=%b flag=%b exp all 0",
               mode, result, busy, valid, state_dbg, flag);
    end
    rst = 1'b0;
    run_eval(n, r, f, to);
    checks++;
    if (to || n != 5 || r !== 8'h36 || f !== 1'b1) begin
      errors++;
      $display("FAIL rst_reeval got to=%0d lat=%0d res=%h flag=%b exp lat=5 res=36 flag=1", to, n, r, f);
    end
  endtask

  task automatic test_random();
    int nv, nc, n, el, tm, s, a, b;
    logic [7:0] r, er; logic f, ef; bit to;
    logic [8:0] exp_v;
    for (int it = 0; it < 16; it++) begin
      tm = $urandom_range(0, 3);
      while (cur_mode != tm) begin
        press(1'b1, 1'b0, 8, nv, nc, r, f);
        cur_mode = (cur_mode + 1) % 4;
        model(cur_mode, cur_sub, cur_a, cur_b, er, ef, el);
        checks++;
        if (mode !== 2'(cur_mode) || nv != 1 || r !== er || f !== ef) begin
          errors++;
          $display("FAIL rand_mode_%0d got mode=%0d valids=%0d res=%h flag=%b exp mode=%0d valids=1 res=%h flag=%b",
                   it, mode, nv, r, f, cur_mode, er, ef);
        end
      end
      s = $urandom_range(0, 3); a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      if (s == cur_sub && a == cur_a && b == cur_b) a = (a + 1) % 16;
      drive(s, a, b);
      model(cur_mode, s, a, b, er, ef, el);
      exp_q.push_back({ef, er});
      run_eval(n, r, f, to);
      exp_v = exp_q.pop_front();
      checks++;
      if (to || n != el || {f, r} !== exp_v) begin
        errors++;
        $display("FAIL rand_op_%0d m=%0d s=%0d a=%0d b=%0d got to=%0d lat=%0d res=%h flag=%b exp lat=%0d res=%h flag=%b",
                 it, cur_mode, s, a, b, to, n, r, f, el, exp_v[7:0], exp_v[8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_div();
    test_keys();
    test_key_while_busy();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
